onchip_mem_port_arbiter: RTL

Arbitrates port 2 of the 256 x 32 Nios on-chip RAM between two hardware masters in the Ethernet packet analyzer: requester A (packet capture writer) and requester B (statistics/descriptor reader). It serialises their single-word read/write commands onto the RAM's second Avalon slave port (s2) and returns read data to the issuing requester. Port 1 (s1) stays on the Nios data master and is outside this block's scope.

---
 rtl/onchip_arb_pkg.sv | 46 ++++
 rtl/onchip_arb_rr_core.sv | 97 +++++++++
 rtl/onchip_mem_port_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/onchip_arb_pkg.sv
// ---------------------------------------------------------------------------
// onchip_arb_pkg
//
// Shared types and constants for the on-chip RAM port-2 arbiter.
//   owner_e    : which requester received the most recent grant
//   rd_pend_t  : one-deep read tracker {valid, owner}
//   ARB_AW     : default word address width (256 words)
//   RUN_W      : width of the A run counter
//   STAT_W     : width of the optional statistics counters
//   stat_next  : saturating counter update with synchronous clear
// ---------------------------------------------------------------------------
package onchip_arb_pkg;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_pend_t;

    localparam int ARB_AW = 8;
    localparam int RUN_W  = 4;
    localparam int STAT_W = 16;

    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    // Clear wins over increment; the counter sticks at all-ones.
    function automatic logic [STAT_W-1:0] stat_next(
        input logic [STAT_W-1:0] cur,
        input logic              clr,
        input logic              inc
    );
        logic [STAT_W-1:0] nxt;
        nxt = cur;
        if (clr) begin
            nxt = '0;
        end else if (inc && (cur != STAT_MAX)) begin
            nxt = cur + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/onchip_arb_rr_core.sv
// ---------------------------------------------------------------------------
// onchip_arb_rr_core
//
// Grant decision for the two requesters sharing RAM port 2. A wins ties
// until it has been granted MAX_RUN times in a row while B was waiting;
// then B gets one grant. The last_owner FSM has two states (OWN_A, OWN_B)
// and resets to OWN_B so that A wins the first tie.
//
// Ports
//   clk      in   clock
//   reset_n  in   synchronous active-low reset
//   a_req    in   requester A command valid
//   b_req    in   requester B command valid
//   a_gnt    out  A command accepted this cycle (combinational)
//   b_gnt    out  B command accepted this cycle (combinational)
//
// The current owner is held in owner_q and the run length in run_cnt_q;
// both are plain named flops so they can be observed hierarchically.
// ---------------------------------------------------------------------------
module onchip_arb_rr_core
    import onchip_arb_pkg::*;
#(
    parameter int MAX_RUN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic a_req,
    input  logic b_req,
    output logic a_gnt,
    output logic b_gnt
);

    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_RUN);

    owner_e           owner_q;
    owner_e           owner_d;
    logic [RUN_W-1:0] run_cnt_q;
    logic [RUN_W-1:0] run_cnt_d;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner_q   <= OWN_B;
            run_cnt_q <= '0;
        end else begin
            owner_q   <= owner_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    // ---------------------------------------------------------------
    // Output logic: grants. Nothing is granted while reset is held so
    // that no command reaches the RAM during reset.
    // ---------------------------------------------------------------
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (reset_n) begin
            if (a_req && !b_req) begin
                a_gnt = 1'b1;
            end else if (b_req && !a_req) begin
                b_gnt = 1'b1;
            end else if (a_req && b_req) begin
                // B takes over only after A has used its full run.
                if ((owner_q == OWN_A) && (run_cnt_q >= RUN_LIMIT)) begin
                    b_gnt = 1'b1;
                end else begin
                    a_gnt = 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic: owner follows the grant; run_cnt counts A grants
    // made against a waiting B and restarts whenever B is served or idle.
    // ---------------------------------------------------------------
    always_comb begin
        owner_d   = owner_q;
        run_cnt_d = run_cnt_q;

        if (a_gnt) begin
            owner_d = OWN_A;
        end else if (b_gnt) begin
            owner_d = OWN_B;
        end

        if (b_gnt || !b_req) begin
            run_cnt_d = '0;
        end else if (a_gnt && (run_cnt_q < RUN_LIMIT)) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/onchip_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_mem_port_arbiter
//
// Shares port 2 (s2) of the 256 x 32 Nios on-chip RAM between requester A
// (packet capture writer) and requester B (statistics/descriptor reader).
// One single-word command is issued per cycle; read data returns to the
// requester that issued the read one cycle after its grant.
//
// Parameters
//   MAX_RUN  consecutive A grants allowed while B waits (1..15)
//   AW       word address width
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   a_req/b_req                  command valid, held until *_gnt
//   a_we/b_we                    1 = write, 0 = read
//   a_addr/b_addr [AW]           word address
//   a_be/b_be [4]                byte enables
//   a_wdata/b_wdata [32]         write data
//   a_gnt/b_gnt                  command accepted (one-cycle pulse)
//   a_rvalid/b_rvalid            read data valid (one-cycle pulse)
//   a_rdata/b_rdata [32]         read data, zero when not valid
//   mem_address [AW]             -> address2
//   mem_byteenable [4]           -> byteenable2
//   mem_chipselect               -> chipselect2, high exactly on a grant
//   mem_write                    -> write2
//   mem_writedata [32]           -> writedata2
//   mem_readdata [32]            <- readdata2 (one-cycle RAM latency)
//   mem_clken                    -> clken2, constant 1
//
// Optional build macro ONCHIP_ARB_STATS_EN adds:
//   stat_clear                   in   synchronous clear of all counters
//   stat_a_grants [16]           out  saturating count of A grants
//   stat_b_grants [16]           out  saturating count of B grants
//   stat_conflicts [16]          out  saturating count of cycles with
//                                     both requests high
// ---------------------------------------------------------------------------
module onchip_mem_port_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int MAX_RUN = 4,
    parameter int AW      = ARB_AW
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [AW-1:0]     a_addr,
    input  logic [3:0]        a_be,
    input  logic [31:0]       a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [31:0]       a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [AW-1:0]     b_addr,
    input  logic [3:0]        b_be,
    input  logic [31:0]       b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [31:0]       b_rdata,

`ifdef ONCHIP_ARB_STATS_EN
    input  logic              stat_clear,
    output logic [STAT_W-1:0] stat_a_grants,
    output logic [STAT_W-1:0] stat_b_grants,
    output logic [STAT_W-1:0] stat_conflicts,
`endif

    output logic [AW-1:0]     mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              mem_clken
);

    // ---------------------------------------------------------------
    // Grant decision
    // ---------------------------------------------------------------
    onchip_arb_rr_core #(
        .MAX_RUN (MAX_RUN)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .a_req   (a_req),
        .b_req   (b_req),
        .a_gnt   (a_gnt),
        .b_gnt   (b_gnt)
    );

    // ---------------------------------------------------------------
    // Command mux: the granted command goes to the RAM in the grant cycle.
    // Address/data simply follow A when nothing is granted; chipselect
    // and write stay low so the RAM ignores them.
    // ---------------------------------------------------------------
    always_comb begin
        mem_chipselect = a_gnt | b_gnt;
        mem_write      = 1'b0;
        mem_address    = a_addr;
        mem_byteenable = a_be;
        mem_writedata  = a_wdata;
        if (b_gnt) begin
            mem_address    = b_addr;
            mem_byteenable = b_be;
            mem_writedata  = b_wdata;
            mem_write      = b_we;
        end else if (a_gnt) begin
            mem_write      = a_we;
        end
    end

    assign mem_clken = 1'b1;

    // ---------------------------------------------------------------
    // Read tracking: the RAM returns data one cycle after the read is
    // presented, so remembering who issued it for one cycle is enough.
    // ---------------------------------------------------------------
    rd_pend_t rd_pend_q;
    rd_pend_t rd_pend_d;

    always_comb begin
        rd_pend_d.valid = (a_gnt & ~a_we) | (b_gnt & ~b_we);
        rd_pend_d.owner = b_gnt ? OWN_B : OWN_A;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_pend_q <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
        end
    end

    // Responses are masked while reset is held so a read caught by reset
    // never produces a late rvalid.
    always_comb begin
        a_rvalid = reset_n & rd_pend_q.valid & (rd_pend_q.owner == OWN_A);
        b_rvalid = reset_n & rd_pend_q.valid & (rd_pend_q.owner == OWN_B);
        a_rdata  = a_rvalid ? mem_readdata : 32'h0;
        b_rdata  = b_rvalid ? mem_readdata : 32'h0;
    end

`ifdef ONCHIP_ARB_STATS_EN
    // ---------------------------------------------------------------
    // Statistics counters (saturating, clear has priority)
    // ---------------------------------------------------------------
    logic [STAT_W-1:0] stat_a_q;
    logic [STAT_W-1:0] stat_a_d;
    logic [STAT_W-1:0] stat_b_q;
    logic [STAT_W-1:0] stat_b_d;
    logic [STAT_W-1:0] stat_c_q;
    logic [STAT_W-1:0] stat_c_d;

    always_comb begin
        stat_a_d = stat_next(stat_a_q, stat_clear, a_gnt);
        stat_b_d = stat_next(stat_b_q, stat_clear, b_gnt);
        stat_c_d = stat_next(stat_c_q, stat_clear, a_req & b_req);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_a_q <= '0;
            stat_b_q <= '0;
            stat_c_q <= '0;
        end else begin
            stat_a_q <= stat_a_d;
            stat_b_q <= stat_b_d;
            stat_c_q <= stat_c_d;
        end
    end

    assign stat_a_grants  = stat_a_q;
    assign stat_b_grants  = stat_b_q;
    assign stat_conflicts = stat_c_q;
`endif

endmodule
